tcdm_bank_arbiter: RTL and testbench
====================================

TCDM_BANK_ARBITER -- requirements
Module: tcdm_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NbPorts, default 4, meaning the number of requesters sharing one bank (2..16).
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the data width.
REQ-003 The block SHALL have parameter AddrWidth, default 32, meaning the address width.
REQ-004 The block SHALL have parameter BeWidth, default DataWidth/8, meaning the byte-enable width.
REQ-005 The block SHALL have port clk_i  in  1  meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_i  in  1  meaning the reset, synchronous and active-high.
REQ-007 The block SHALL have port req_i  in  NbPorts  meaning the per-port request.
REQ-008 The block SHALL have port gnt_o  out  NbPorts  meaning the per-port grant, one-hot or zero.
REQ-009 The block SHALL have port add_i  in  NbPorts x AddrWidth  meaning the per-port byte address.
REQ-010 The block SHALL have port wen_i  in  NbPorts  meaning the per-port write enable, active-low (1 = read).
REQ-011 The block SHALL have port data_i  in  NbPorts x DataWidth  meaning the per-port write data.
REQ-012 The block SHALL have port be_i  in  NbPorts x BeWidth  meaning the per-port byte enable.
REQ-013 The block SHALL have port r_data_o  out  DataWidth  meaning the read data, broadcast to all ports.
REQ-014 The block SHALL have port r_valid_o  out  NbPorts  meaning the per-port response valid.
REQ-015 The block SHALL have port bank_req_o  out  1  meaning the bank request.
REQ-016 The block SHALL have port bank_gnt_i  in  1  meaning the bank ready; when 0, the bank accepts nothing.
REQ-017 The block SHALL have ports bank_add_o, bank_wen_o, bank_data_o and bank_be_o  out  AddrWidth/1/DataWidth/BeWidth  meaning the muxed winner fields.
REQ-018 The block SHALL have port bank_r_data_i  in  DataWidth  meaning the bank read data, valid 1 cycle after an accepted request.

Function
REQ-019 The block SHALL select the winner combinationally by round-robin: the first asserted req_i scanning upward from pointer ptr_q, wrapping past NbPorts-1 to 0.
REQ-020 The block SHALL drive bank_req_o = |req_i and drive the bank_* fields from the winner; fields are don't-care when no request is present.
REQ-021 The block SHALL assert gnt_o[k] only when k wins and bank_gnt_i=1, with zero-cycle grant latency.
REQ-022 On a grant to port k, the block SHALL set ptr_q to (k+1) mod NbPorts; otherwise ptr_q holds, including when bank_gnt_i=0.
REQ-023 The block SHALL register the granted port index and assert r_valid_o[k] for exactly one cycle, the cycle after the grant, for both reads and writes.
REQ-024 The block SHALL pass r_data_o = bank_r_data_i unregistered; r_data_o is meaningful only with a read response.
REQ-025 Back-to-back grants SHALL be sustained at 1 per cycle, and response N SHALL coincide with grant N+1.
REQ-026 A single requester SHALL be granted every cycle while bank_gnt_i=1.
REQ-027 A requester deasserting req_i without a grant SHALL lose nothing: no response and no pointer change.

Reset
REQ-028 While rst_i=1, the block SHALL set ptr_q to 0 and the response-valid register to 0, and clear the conflict counter when compiled in.
REQ-029 While rst_i=1, the block SHALL hold gnt_o=0, bank_req_o=0 and r_valid_o=0, regardless of req_i.
REQ-030 A reset asserted in the cycle after a grant SHALL drop that pending response: no r_valid_o.

Configuration
REQ-031 With macro TCDM_ARB_PERF_EN defined, the block SHALL add input perf_clr_i (1) and output perf_conflicts_o (32).
REQ-032 With TCDM_ARB_PERF_EN defined, the counter SHALL increment each cycle in which at least 2 req_i bits are set, saturate at 2^32-1, and clear synchronously on perf_clr_i, with clear taking precedence over increment.
REQ-033 Without TCDM_ARB_PERF_EN, the block SHALL have neither port nor counter, and arbitration behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL cover: after reset, req_i=4'b1111 held for 8 cycles with bank_gnt_i=1 -> gnt_o sequence 0001,0010,0100,1000,0001,... and r_valid_o the same, shifted by +1 cycle.
REQ-035 The bench SHALL cover: req_i=4'b1010 with ptr_q=0 -> grant port 1, then port 3, then port 1.
REQ-036 The bench SHALL cover: bank_gnt_i=0 for 3 cycles with req_i=4'b0100 -> gnt_o=0, no r_valid_o and ptr_q unchanged; then bank_gnt_i=1 -> gnt_o=0100 and r_valid_o[2] on the next cycle.
REQ-037 The bench SHALL cover: port 2 write of 0xDEADBEEF to address 0x10, then a port 0 read of 0x10 -> r_valid_o[0] with r_data_o=0xDEADBEEF, using a 1-cycle bank model.
REQ-038 The bench SHALL cover: rst_i pulsed the cycle after a grant to port 3 -> r_valid_o stays 0 and the next grant from req_i=1111 goes to port 0.
REQ-039 The bench SHALL cover, with TCDM_ARB_PERF_EN: 5 cycles of req_i=0011 and 2 cycles of 0001 -> perf_conflicts_o=5; perf_clr_i -> 0 on the next cycle.

Source files
------------

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter granting NbPorts requesters access to one single-cycle TCDM bank.
// Optional conflict counter enabled with macro TCDM_ARB_PERF_EN.
module tcdm_bank_arbiter #(
    parameter int unsigned NbPorts   = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NbPorts-1:0]                  req_i,
    output logic [NbPorts-1:0]                  gnt_o,
    input  logic [NbPorts-1:0][AddrWidth-1:0]   add_i,
    input  logic [NbPorts-1:0]                  wen_i,
    input  logic [NbPorts-1:0][DataWidth-1:0]   data_i,
    input  logic [NbPorts-1:0][BeWidth-1:0]     be_i,
    output logic [DataWidth-1:0]                r_data_o,
    output logic [NbPorts-1:0]                  r_valid_o,
    output logic                                bank_req_o,
    input  logic                                bank_gnt_i,
    output logic [AddrWidth-1:0]                bank_add_o,
    output logic                                bank_wen_o,
    output logic [DataWidth-1:0]                bank_data_o,
    output logic [BeWidth-1:0]                  bank_be_o,
    input  logic [DataWidth-1:0]                bank_r_data_i
`ifdef TCDM_ARB_PERF_EN
    ,
    input  logic                                perf_clr_i,
    output logic [31:0]                         perf_conflicts_o
`endif
);

    localparam int unsigned IdxWidth = $clog2(NbPorts);

    logic [IdxWidth-1:0] ptr_reg;
    logic [IdxWidth-1:0] ptr_next;
    logic [IdxWidth-1:0] rsp_idx_reg;
    logic                rsp_valid_reg;
    logic [IdxWidth-1:0] winner;
    logic                grant_any;

    logic [IdxWidth-1:0] cand_idx [NbPorts];
    logic [IdxWidth-1:0] win_acc  [NbPorts+1];
    logic [NbPorts-1:0]  rot_req;
    logic [NbPorts-1:0]  seen;
    logic [NbPorts-1:0]  first;

    // Slot gi of the rotated view holds port (ptr + gi) mod NbPorts; the lowest
    // asserted slot wins, and its port index is OR-reduced into the winner.
    assign win_acc[0] = '0;
    for (genvar gi = 0; gi < NbPorts; gi++) begin : g_rr
        logic [IdxWidth:0] sum;
        assign sum          = {1'b0, ptr_reg} + (IdxWidth+1)'(gi);
        assign cand_idx[gi] = (sum >= (IdxWidth+1)'(NbPorts)) ?
                              IdxWidth'(sum - (IdxWidth+1)'(NbPorts)) : sum[IdxWidth-1:0];
        assign rot_req[gi]  = req_i[cand_idx[gi]];
        if (gi == 0) begin : g_seen0
            assign seen[gi] = 1'b0;
        end else begin : g_seenn
            assign seen[gi] = seen[gi-1] | rot_req[gi-1];
        end
        assign first[gi]     = rot_req[gi] & ~seen[gi];
        assign win_acc[gi+1] = win_acc[gi] | ({IdxWidth{first[gi]}} & cand_idx[gi]);
    end

    assign winner    = win_acc[NbPorts];
    assign grant_any = (|req_i) & bank_gnt_i & ~rst_i;

    assign ptr_next = !grant_any ? ptr_reg :
                      (winner == IdxWidth'(NbPorts - 1)) ? '0 : winner + IdxWidth'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_idx_reg   <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            rsp_valid_reg <= grant_any;
            if (grant_any) begin
                rsp_idx_reg <= winner;
            end
        end
    end

    // A reset in the response cycle suppresses the pending response immediately.
    for (genvar gi = 0; gi < NbPorts; gi++) begin : g_out
        assign gnt_o[gi]     = grant_any & (winner == IdxWidth'(gi));
        assign r_valid_o[gi] = rsp_valid_reg & ~rst_i & (rsp_idx_reg == IdxWidth'(gi));
    end

    assign bank_req_o  = (|req_i) & ~rst_i;
    assign bank_add_o  = add_i[winner];
    assign bank_wen_o  = wen_i[winner];
    assign bank_data_o = data_i[winner];
    assign bank_be_o   = be_i[winner];
    assign r_data_o    = bank_r_data_i;

`ifdef TCDM_ARB_PERF_EN
    logic [31:0] conflicts_reg;
    logic        multi_req;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_req = |(req_i & (req_i - NbPorts'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            conflicts_reg <= '0;
        end else if (multi_req && (conflicts_reg != '1)) begin
            conflicts_reg <= conflicts_reg + 32'd1;
        end
    end

    assign perf_conflicts_o = conflicts_reg;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Self-checking bench for tcdm_bank_arbiter: directed scenarios plus random traffic
// against a round-robin reference model and a 1-cycle bank memory model.
module tb_tcdm_bank_arbiter;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [3:0]        gnt;
    logic [3:0][31:0]  add;
    logic [3:0]        wen;
    logic [3:0][31:0]  wdata;
    logic [3:0][3:0]   be;
    logic [31:0]       r_data;
    logic [3:0]        r_valid;
    logic              bank_req;
    logic              bank_gnt;
    logic [31:0]       bank_add;
    logic              bank_wen;
    logic [31:0]       bank_wdata;
    logic [3:0]        bank_be;
    logic [31:0]       bank_rdata;
`ifdef TCDM_ARB_PERF_EN
    logic              perf_clr;
    logic [31:0]       perf_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr  = 0;
    int          m_resp = -1;
    logic        m_resp_rd = 1'b0;
    logic [31:0] m_rdata = '0;
    longint      m_cnt  = 0;
    logic [31:0] ref_mem  [16];
    logic [31:0] bank_mem [16];

    tcdm_bank_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .gnt_o        (gnt),
        .add_i        (add),
        .wen_i        (wen),
        .data_i       (wdata),
        .be_i         (be),
        .r_data_o     (r_data),
        .r_valid_o    (r_valid),
        .bank_req_o   (bank_req),
        .bank_gnt_i   (bank_gnt),
        .bank_add_o   (bank_add),
        .bank_wen_o   (bank_wen),
        .bank_data_o  (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_r_data_i(bank_rdata)
`ifdef TCDM_ARB_PERF_EN
        ,
        .perf_clr_i      (perf_clr),
        .perf_conflicts_o(perf_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank: accepts on bank_req & bank_gnt, read data appears one cycle later.
    always @(posedge clk) begin
        if (bank_req && bank_gnt) begin
            if (!bank_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (bank_be[b]) bank_mem[bank_add[5:2]][8*b +: 8] <= bank_wdata[8*b +: 8];
                end
            end else begin
                bank_rdata <= bank_mem[bank_add[5:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance it.
    task automatic step(input string tag, input int dir_gnt = -1, input int dir_rv = -1);
        int         w;
        logic [3:0] eg;
        logic [3:0] ev;
        #1;
        w = -1;
        if (!rst && bank_gnt && req != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (w < 0 && req[k]) w = k;
            end
        end
        eg = (w >= 0) ? 4'(1 << w) : 4'b0;
        ev = (!rst && m_resp >= 0) ? 4'(1 << m_resp) : 4'b0;
        chk({tag, " gnt"}, 64'(gnt), 64'(eg));
        chk({tag, " r_valid"}, 64'(r_valid), 64'(ev));
        chk({tag, " bank_req"}, 64'(bank_req), 64'(!rst && req != 4'b0));
        if (dir_gnt >= 0) chk({tag, " seq_gnt"}, 64'(gnt), 64'(dir_gnt));
        if (dir_rv >= 0) chk({tag, " seq_r_valid"}, 64'(r_valid), 64'(dir_rv));
        if (!rst && m_resp >= 0 && m_resp_rd) chk({tag, " r_data"}, 64'(r_data), 64'(m_rdata));
        if (w >= 0) begin
            chk({tag, " bank_add"}, 64'(bank_add), 64'(add[w]));
            chk({tag, " bank_wen"}, 64'(bank_wen), 64'(wen[w]));
            if (!wen[w]) begin
                chk({tag, " bank_data"}, 64'(bank_wdata), 64'(wdata[w]));
                chk({tag, " bank_be"}, 64'(bank_be), 64'(be[w]));
            end
            $display("[%0t] %s: grant port %0d %s addr=%h", $time, tag, w,
                     wen[w] ? "rd" : "wr", add[w]);
        end
`ifdef TCDM_ARB_PERF_EN
        chk({tag, " perf"}, 64'(perf_cnt), 64'(m_cnt));
`endif
        @(posedge clk);
        if (rst) begin
            m_ptr  = 0;
            m_resp = -1;
            m_cnt  = 0;
        end else begin
            m_resp = w;
            if (w >= 0) begin
                m_ptr     = (w + 1) % 4;
                m_resp_rd = wen[w];
                if (wen[w]) begin
                    m_rdata = ref_mem[add[w][5:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[add[w][5:2]][8*b +: 8] = wdata[w][8*b +: 8];
                end
            end
`ifdef TCDM_ARB_PERF_EN
            if (perf_clr) m_cnt = 0;
            else if ($countones(req) >= 2 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        int seq [8];
        seq = '{1, 2, 4, 8, 1, 2, 4, 8};
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = '0;
            bank_mem[i] = '0;
        end
        bank_rdata = '0;
        rst = 1'b1; req = 4'b0; bank_gnt = 1'b1; wen = 4'hF;
        for (int p = 0; p < 4; p++) begin
            add[p] = '0; wdata[p] = '0; be[p] = 4'hF;
        end
`ifdef TCDM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        @(negedge clk);

        // Reset holds everything quiet regardless of requests
        req = 4'b1111;
        step("reset0", 0, 0);
        step("reset1", 0, 0);
        rst = 1'b0;

        // All ports requesting: rotating grants, responses one cycle behind
        for (int i = 0; i < 8; i++) step("rr_all", seq[i], (i == 0) ? 0 : seq[i-1]);
        req = 4'b0;
        step("rr_tail", 0, 8);

        // Sparse requests from pointer 0
        rst = 1'b1; step("rst_b");
        rst = 1'b0; req = 4'b1010;
        step("sparse0", 2);
        step("sparse1", 8, 2);
        step("sparse2", 2, 8);
        req = 4'b0;
        step("sparse_tail", 0, 2);

        // Bank stall: nothing granted, nothing responded, pointer holds
        req = 4'b0100; bank_gnt = 1'b0;
        for (int i = 0; i < 3; i++) step("stall", 0, 0);
        bank_gnt = 1'b1;
        step("stall_release", 4, 0);
        req = 4'b0;
        step("stall_rsp", 0, 4);

        // Write from port 2 then read back through port 0
        req = 4'b0100; wen[2] = 1'b0; add[2] = 32'h10; wdata[2] = 32'hDEADBEEF; be[2] = 4'hF;
        step("wr_p2", 4);
        req = 4'b0001; wen[0] = 1'b1; add[0] = 32'h10; wen[2] = 1'b1;
        step("rd_p0", 1, 4);
        req = 4'b0;
        #1 chk("rd_p0 data", 64'(r_data), 64'(32'hDEADBEEF));
        step("rd_rsp", 0, 1);

        // Reset right after a grant to port 3 drops the response
        rst = 1'b1; step("rst_c");
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 4; i++) step("to_p3", seq[i]);
        rst = 1'b1;
        step("rst_drop", 0, 0);
        rst = 1'b0;
        step("after_drop", 1, 0);

`ifdef TCDM_ARB_PERF_EN
        req = 4'b0; perf_clr = 1'b1; step("perf_clr0");
        perf_clr = 1'b0;
        req = 4'b0011; for (int i = 0; i < 5; i++) step("perf_conf");
        req = 4'b0001; for (int i = 0; i < 2; i++) step("perf_single");
        req = 4'b0;
        #1 chk("perf_five", 64'(perf_cnt), 64'd5);
        perf_clr = 1'b1; step("perf_clr1");
        perf_clr = 1'b0;
        #1 chk("perf_zero", 64'(perf_cnt), 64'd0);
        step("perf_idle");
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            req      = 4'($urandom_range(0, 15));
            bank_gnt = ($urandom_range(0, 9) < 8);
            rst      = ($urandom_range(0, 99) < 2);
            for (int p = 0; p < 4; p++) begin
                wen[p]   = $urandom_range(0, 1) == 1;
                add[p]   = 32'($urandom_range(0, 15)) << 2;
                wdata[p] = $urandom;
                be[p]    = 4'($urandom_range(0, 15));
            end
`ifdef TCDM_ARB_PERF_EN
            perf_clr = ($urandom_range(0, 49) == 0);
`endif
            step("rand");
        end
        rst = 1'b0; req = 4'b0;
        step("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
